// File: rtl/vga_framebuffer.sv
// vga_framebuffer
//   160x120 RRGGBB frame store feeding a 640x480 VGA controller with a 4x4
//   upscale. Scanout runs one scan pixel ahead so the colour for the
//   controller's current (x, y) is already registered when it is needed.
//   Drawing logic writes single pixels through a valid/ready port; a clear
//   engine fills the whole frame at one word per cycle.
//
// Ports
//   vga_clock      25 MHz pixel clock shared with the controller
//   reset          synchronous, active-high
//   x, y           current scan coordinate from the controller
//   pixel_colour   colour for (x, y), 0 outside the visible area
//   plot_x/y       write coordinate, plot_colour write data
//   plot_valid     write request; plot_ready accepts it
//   plot_dropped   one-cycle pulse after an accepted out-of-range write
//   clear_start    start a full-frame fill with clear_colour
//   busy           clear engine active
//   swap_req       (double-buffer build) request a bank flip at next vblank
//   swap_done      (double-buffer build) pulses in the cycle the flip happens
//
// Build option
//   VGA_FRAMEBUFFER_DOUBLE_BUFFER_EN : two banks; scanout reads the front
//   bank, writes and clears go to the back bank.
//
// Clear FSM
//   state | meaning
//   IDLE  | accepting plot writes, waiting for clear_start
//   FILL  | writing clear colour to one address per cycle, plot_ready low

module vga_framebuffer #(
    parameter int FB_WIDTH    = 160,
    parameter int FB_HEIGHT   = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic [5:0] pixel_colour,
    input  logic [7:0] plot_x,
    input  logic [6:0] plot_y,
    input  logic [5:0] plot_colour,
    input  logic       plot_valid,
    output logic       plot_ready,
    output logic       plot_dropped,
    input  logic       clear_start,
    input  logic [5:0] clear_colour,
`ifdef VGA_FRAMEBUFFER_DOUBLE_BUFFER_EN
    input  logic       swap_req,
    output logic       swap_done,
`endif
    output logic       busy
);

    localparam int FB_WORDS = FB_WIDTH * FB_HEIGHT;
`ifdef VGA_FRAMEBUFFER_DOUBLE_BUFFER_EN
    localparam int MEM_WORDS = 2 * FB_WORDS;
`else
    localparam int MEM_WORDS = FB_WORDS;
`endif
    localparam int MEM_AW = $clog2(MEM_WORDS);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    // fy*160 + fx without a multiplier
    function automatic logic [14:0] fb_addr(input logic [6:0] fy, input logic [7:0] fx);
        return ({8'd0, fy} << 7) + ({8'd0, fy} << 5) + {7'd0, fx};
    endfunction

    logic [5:0]        mem [MEM_WORDS];
    logic [5:0]        rd_data_q;

    logic [0:0]        state_q, state_d;
    logic [14:0]       cnt_q, cnt_d;
    logic [5:0]        colour_q, colour_d;
    logic              dropped_q, dropped_d;
    logic              vis_q, vis_d;

    logic [9:0]        nx;
    logic [8:0]        ny;
    logic [14:0]       rd_addr;
    logic [MEM_AW-1:0] rd_idx;
    logic [MEM_AW-1:0] wr_idx;
    logic [14:0]       wr_addr;
    logic [5:0]        wr_data;
    logic              wr_en;
    logic              accept;
    logic              in_range;
    logic              rd_bank;
    logic              wr_bank;

`ifdef VGA_FRAMEBUFFER_DOUBLE_BUFFER_EN
    logic front_q, front_d;
    logic pend_q, pend_d;
    logic flip;
`endif

    assign busy         = (state_q == FILL);
    assign plot_ready   = !reset && (state_q == IDLE);
    assign plot_dropped = dropped_q;
    assign pixel_colour = vis_q ? rd_data_q : 6'd0;

    // Next scan coordinate: the controller advances one column per cycle.
    always_comb begin
        nx = x + 10'd1;
        ny = y;
        if (x == 10'(H_TOTAL - 1)) begin
            nx = 10'd0;
            ny = (y == 9'(V_TOTAL - 1)) ? 9'd0 : y + 9'd1;
        end
        vis_d   = (nx < 10'(H_VISIBLE)) && (ny < 9'(V_VISIBLE));
        // Blanking coordinates fall outside the array; park the read at 0.
        rd_addr = vis_d ? fb_addr(7'(ny >> SCALE_SHIFT), 8'(nx >> SCALE_SHIFT)) : 15'd0;
    end

`ifdef VGA_FRAMEBUFFER_DOUBLE_BUFFER_EN
    always_comb begin
        // Flip only at the start of vblank, and never while a clear is
        // still filling the back bank.
        flip      = !reset && pend_q && (state_q == IDLE)
                    && (x == 10'd0) && (y == 9'(V_VISIBLE));
        swap_done = flip;
        pend_d    = flip ? 1'b0 : (pend_q | swap_req);
        front_d   = flip ? ~front_q : front_q;
        rd_bank   = front_q;
        wr_bank   = ~front_q;
    end
`else
    assign rd_bank = 1'b0;
    assign wr_bank = 1'b0;
`endif

    always_comb begin
        rd_idx = MEM_AW'(rd_addr) + (rd_bank ? MEM_AW'(FB_WORDS) : MEM_AW'(0));
        wr_idx = MEM_AW'(wr_addr) + (wr_bank ? MEM_AW'(FB_WORDS) : MEM_AW'(0));
    end

    // Write port: fill has priority, but it never overlaps a plot because
    // plot_ready is low for the whole fill.
    always_comb begin
        accept    = plot_valid && plot_ready;
        in_range  = (plot_x < 8'(FB_WIDTH)) && (plot_y < 7'(FB_HEIGHT));
        dropped_d = accept && !in_range;
        wr_en     = 1'b0;
        wr_addr   = 15'd0;
        wr_data   = 6'd0;
        if (!reset) begin
            if (state_q == FILL) begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = colour_q;
            end else if (accept && in_range) begin
                wr_en   = 1'b1;
                wr_addr = fb_addr(plot_y, plot_x);
                wr_data = plot_colour;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        colour_d = colour_q;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d  = FILL;
                    cnt_d    = 15'd0;
                    colour_d = clear_colour;
                end
            end
            FILL: begin
                if (cnt_q == 15'(FB_WORDS - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 15'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 15'd0;
            colour_q  <= 6'd0;
            dropped_q <= 1'b0;
            vis_q     <= 1'b0;
`ifdef VGA_FRAMEBUFFER_DOUBLE_BUFFER_EN
            front_q   <= 1'b0;
            pend_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            colour_q  <= colour_d;
            dropped_q <= dropped_d;
            vis_q     <= vis_d;
`ifdef VGA_FRAMEBUFFER_DOUBLE_BUFFER_EN
            front_q   <= front_d;
            pend_q    <= pend_d;
`endif
        end
    end

    // RAM: no reset so it maps onto block memory. The read returns the
    // old word when it collides with a write in the same cycle.
    always_ff @(posedge vga_clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_data_q <= mem[rd_idx];
    end

endmodule

// File: tb/tb_vga_framebuffer.sv
module tb_vga_framebuffer;

    localparam int HT = 800;
    localparam int VT = 525;
    localparam int HV = 640;
    localparam int VV = 480;
    localparam int FBW = 160;
    localparam int FBH = 120;

    logic       vga_clock = 1'b0;
    logic       reset;
    logic [9:0] x;
    logic [8:0] y;
    logic [5:0] pixel_colour;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [5:0] plot_colour;
    logic       plot_valid;
    logic       plot_ready;
    logic       plot_dropped;
    logic       clear_start;
    logic [5:0] clear_colour;
    logic       busy;
`ifdef VGA_FRAMEBUFFER_DOUBLE_BUFFER_EN
    logic       swap_req;
    logic       swap_done;
`endif

    always #5 vga_clock = ~vga_clock;

    vga_framebuffer dut (
        .vga_clock    (vga_clock),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .pixel_colour (pixel_colour),
        .plot_x       (plot_x),
        .plot_y       (plot_y),
        .plot_colour  (plot_colour),
        .plot_valid   (plot_valid),
        .plot_ready   (plot_ready),
        .plot_dropped (plot_dropped),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
`ifdef VGA_FRAMEBUFFER_DOUBLE_BUFFER_EN
        .swap_req     (swap_req),
        .swap_done    (swap_done),
`endif
        .busy         (busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t x=%0d y=%0d)", nm, act, exp, $time, x, y);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame contents as the drawing side sees them, plus the scan pixel the
    // DUT owes for the coming cycle.
    logic [5:0] m_mem [FBW*FBH];
    bit         m_fill = 0;
    int         m_pos = 0;
    logic [5:0] m_fcol = 6'd0;
    bit         m_drop = 0;
    bit         started = 0;
    bit         exp_zero = 0;
    int         exp_x = -1;
    int         exp_y = -1;
    logic [5:0] exp_pix = 6'd0;

    initial begin
        int sx, sy, px, py;
        bit acc;
        forever begin
            @(posedge vga_clock);
            started = 1;
            if (reset) begin
                m_fill   = 0;
                m_drop   = 0;
                exp_zero = 1;
            end else begin
                exp_zero = 0;
                // Pixel the controller will be showing next cycle, from the
                // frame as it stood before this edge's writes.
                sx = (int'(x) + 1) % HT;
                sy = (int'(x) == HT - 1) ? (int'(y) + 1) % VT : int'(y);
                exp_x = sx;
                exp_y = sy;
                exp_pix = (sx < HV && sy < VV) ? m_mem[(sy / 4) * FBW + sx / 4] : 6'd0;
                px  = int'(plot_x);
                py  = int'(plot_y);
                acc = plot_valid && !m_fill;
                m_drop = acc && (px >= FBW || py >= FBH);
                if (acc && !m_drop) m_mem[py * FBW + px] = plot_colour;
                if (m_fill) begin
                    m_mem[m_pos] = m_fcol;
                    m_pos++;
                    if (m_pos == FBW * FBH) m_fill = 0;
                end else if (clear_start) begin
                    m_fill = 1;
                    m_pos  = 0;
                    m_fcol = clear_colour;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge vga_clock);
            if (started) begin
                chk("plot_ready", int'(plot_ready), int'(!reset && !m_fill));
                chk("busy", int'(busy), int'(m_fill));
                chk("plot_dropped", int'(plot_dropped), int'(m_drop));
                if (exp_zero)
                    chk("pixel_in_reset", int'(pixel_colour), 0);
                else if (int'(x) == exp_x && int'(y) == exp_y)
                    chk("pixel_model", int'(pixel_colour), int'(exp_pix));
            end
        end
    end

    // ---------------- stimulus ----------------
    // One controller cycle: inputs change 1 time unit after the edge.
    task automatic cyc();
        @(posedge vga_clock);
        #1;
        if (x == 10'(HT - 1)) begin
            x = 10'd0;
            y = (y == 9'(VT - 1)) ? 9'd0 : y + 9'd1;
        end else begin
            x = x + 10'd1;
        end
    endtask

    task automatic at_mid();
        @(negedge vga_clock);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 25000) begin
            cyc();
            n++;
        end
        chk(nm, int'(n < 25000), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rl, rx, ry;
        reset = 1'b1; x = 10'd0; y = 9'd0;
        plot_x = 8'd0; plot_y = 7'd0; plot_colour = 6'd0; plot_valid = 1'b0;
        clear_start = 1'b0; clear_colour = 6'd0;
`ifdef VGA_FRAMEBUFFER_DOUBLE_BUFFER_EN
        swap_req = 1'b0;
`endif
        repeat (3) cyc();
        at_mid();
        chk("rst_ready", int'(plot_ready), 0);
        chk("rst_pixel", int'(pixel_colour), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dropped", int'(plot_dropped), 0);
        cyc();
        reset = 1'b0;
        at_mid();
        chk("ready_after_rst", int'(plot_ready), 1);

        // Known frame contents to start from.
        cyc(); clear_start = 1'b1; clear_colour = 6'd0;
        cyc(); clear_start = 1'b0;
        wait_idle("init_fill_bound");

        // Single write, then scan its 4x4 block and the pixel beyond.
        cyc(); plot_x = 8'd3; plot_y = 7'd2; plot_colour = 6'b110000; plot_valid = 1'b1;
        at_mid(); chk("wr_ready_a", int'(plot_ready), 1);
        cyc(); plot_valid = 1'b0;
        at_mid(); chk("wr_ready_b", int'(plot_ready), 1);
        for (int yy = 8; yy <= 11; yy++) begin
            cyc(); x = 10'd11; y = 9'(yy);
            for (int xx = 12; xx <= 16; xx++) begin
                cyc(); at_mid();
                chk("wr_block", int'(pixel_colour), (xx == 16) ? 0 : 6'b110000);
            end
        end

        // Out-of-range write.
        cyc(); plot_x = 8'd160; plot_y = 7'd5; plot_colour = 6'b111111; plot_valid = 1'b1;
        at_mid(); chk("oob_ready", int'(plot_ready), 1);
        cyc(); plot_valid = 1'b0;
        at_mid(); chk("oob_drop_hi", int'(plot_dropped), 1);
        cyc(); at_mid(); chk("oob_drop_lo", int'(plot_dropped), 0);
        cyc(); x = 10'd635; y = 9'd20;
        repeat (4) cyc();
        at_mid(); chk("oob_last_col", int'(pixel_colour), 0);

        // Random writes ahead of the scan, some out of range.
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (i % 16 == 0) begin
                x = 10'($urandom_range(0, HV - 1));
                y = 9'($urandom_range(0, VV - 1));
            end
            plot_valid  = 1'($urandom % 2);
            plot_colour = 6'($urandom);
            plot_x      = 8'((int'(x) >> 2) + 1 + int'($urandom % 2));
            plot_y      = 7'(int'(y) >> 2);
            if ($urandom % 8 == 0) plot_x = 8'(FBW + $urandom_range(0, 40));
            if ($urandom % 8 == 0) plot_y = 7'(FBH + $urandom_range(0, 7));
        end
        cyc(); plot_valid = 1'b0;

        // Full clear; a second clear_start and a plot during the fill are ignored.
        cyc(); clear_start = 1'b1; clear_colour = 6'b000011;
        cyc(); clear_start = 1'b0;
        n = 0; rl = 0;
        while (busy === 1'b1 && n < 25000) begin
            n++;
            if (plot_ready !== 1'b1) rl++;
            if (n == 50) begin
                clear_start = 1'b1; clear_colour = 6'b110011;
                plot_valid = 1'b1; plot_x = 8'd1; plot_y = 7'd1; plot_colour = 6'b111000;
            end
            if (n == 52) begin
                clear_start = 1'b0; plot_valid = 1'b0;
            end
            cyc();
        end
        chk("fill_cycles", n, 19200);
        chk("fill_ready_low", rl, 19200);
        for (int k = 0; k < 16; k++) begin
            rx = int'($urandom_range(1, HV - 1));
            ry = int'($urandom_range(0, VV - 1));
            cyc(); x = 10'(rx - 1); y = 9'(ry);
            cyc(); at_mid();
            chk("clear_px", int'(pixel_colour), 6'b000011);
        end
        cyc(); x = 10'd4; y = 9'd4;
        cyc(); at_mid(); chk("clear_ignored_plot", int'(pixel_colour), 6'b000011);
        cyc(); x = 10'd699; y = 9'd100;
        cyc(); at_mid(); chk("clear_blank", int'(pixel_colour), 0);

        // Scan wrap and visible-area edges.
        cyc(); plot_x = 8'd0; plot_y = 7'd0; plot_colour = 6'b001100; plot_valid = 1'b1;
        cyc(); plot_x = 8'd159; plot_y = 7'd119; plot_colour = 6'b111111;
        cyc(); plot_valid = 1'b0; x = 10'd798; y = 9'd524;
        cyc(); at_mid(); chk("wrap_blank", int'(pixel_colour), 0);
        cyc(); at_mid(); chk("wrap_origin", int'(pixel_colour), 6'b001100);
        cyc(); x = 10'd638; y = 9'd479;
        cyc(); at_mid(); chk("last_visible", int'(pixel_colour), 6'b111111);
        cyc(); at_mid(); chk("first_hblank", int'(pixel_colour), 0);

        // Plot and clear together, then reset 100 cycles into the fill.
        cyc(); plot_x = 8'd150; plot_y = 7'd0; plot_colour = 6'b101010; plot_valid = 1'b1;
        clear_start = 1'b1; clear_colour = 6'b010101;
        cyc(); plot_valid = 1'b0; clear_start = 1'b0;
        repeat (99) cyc();
        reset = 1'b1;
        cyc(); reset = 1'b0;
        at_mid();
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(plot_ready), 1);
        cyc(); x = 10'd599; y = 9'd0;
        cyc(); at_mid(); chk("abort_addr150", int'(pixel_colour), 6'b101010);
        cyc(); x = 10'd19; y = 9'd0;
        cyc(); at_mid(); chk("abort_addr5", int'(pixel_colour), 6'b010101);
        repeat (5) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
